seq_gen: RTL and testbench
==========================

Name: seq_gen

Overview:
- Serial pattern transmitter. It is the source end of the serial bit stream that the team's sequence detectors consume.
- Accepts a parallel pattern through a valid/ready handshake and shifts it out MSB-first, one bit per clock, on `x`.
- Can repeat the pattern a programmable number of times, with optional idle gaps between repeats.
- Exposes its present state for debug, and pulses `done` when the burst completes.

Parameters:
- WIDTH, 4, pattern length in bits (≥2).
- CNT_W, 4, width of the repeat-count input.
- GAP, 0, idle cycles inserted between consecutive repeats (0 = back-to-back).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  request to begin a burst.
- start_ready  output  1  high when a request can be accepted (IDLE only).
- pattern  input  WIDTH  bits to send; bit WIDTH-1 goes first.
- repeat_n  input  CNT_W  number of pattern transmissions; 0 is treated as 1.
- abort  input  1  synchronous cancel of an in-progress burst.
- x  output  1  serial data bit.
- x_valid  output  1  high on every cycle `x` carries a pattern bit.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse after the last bit of a burst.
- ps  output  2  present state encoding (debug).

Behaviour:
- Clock and reset: one clock (`clk`); `rst` is asynchronous and active-high. All state and outputs are flops, asynchronously cleared by `rst`.
- Reset values: ps=IDLE, x=0, x_valid=0, busy=0, done=0, start_ready=1; shift register, bit counter and repeat counter all 0.
- State encoding: IDLE=2'b00, SHIFT=2'b01, GAP_S=2'b10, DONE=2'b11.
- IDLE:
  - start_ready=1, x=0, x_valid=0.
  - Handshake fires at edge k when start_valid=1 and start_ready=1.
  - At that edge: capture `pattern` into both pat_reg and shreg; rep_cnt = max(repeat_n,1); bit_cnt = WIDTH-1; go to SHIFT.
  - Cycle after edge k: x = pattern[WIDTH-1], x_valid=1, busy=1, start_ready=0.
- SHIFT:
  - Each edge: shreg shifts left by one; bit_cnt decrements; x updates to the next bit.
  - At the edge where the last bit (bit_cnt==0) has been presented:
    - If rep_cnt>1 and GAP>0: decrement rep_cnt, load gap counter = GAP-1, go to GAP_S.
    - If rep_cnt>1 and GAP==0: decrement rep_cnt, reload shreg from pat_reg, bit_cnt=WIDTH-1, stay in SHIFT. There is no bubble; x_valid stays high.
    - Otherwise: go to DONE.
- GAP_S:
  - x=0, x_valid=0, busy=1 for exactly GAP cycles.
  - Then reload shreg from pat_reg, bit_cnt=WIDTH-1, return to SHIFT.
- DONE:
  - done=1, x=0, x_valid=0, busy=1 for exactly one cycle.
  - Then go to IDLE; start_ready=1 on the following cycle.
- Latency and burst length:
  - First bit appears one cycle after the handshake.
  - Burst length = WIDTH·R + GAP·(R-1) cycles, where R = max(repeat_n,1).
  - done asserts on the cycle right after the final bit.
- Input sampling: `pattern` and `repeat_n` are sampled only at the handshake edge. Changes during a burst have no effect.
- start_valid outside IDLE: ignored. The request is neither queued nor acknowledged.
- abort:
  - In SHIFT or GAP_S: next state is IDLE; x=0, x_valid=0, no done pulse; counters cleared.
  - abort in IDLE or DONE has no effect. DONE still completes and done still pulses.
  - If abort and start_valid are both high in IDLE, the handshake proceeds normally.
- Reset mid-burst: outputs take reset values immediately (asynchronously). There is no done pulse and no residual bits after reset is released.
- ps always reflects the registered present state.

Test Plan:
- WIDTH=4, GAP=0, pattern=4'b1011, repeat_n=1, handshake at cycle 0 -> x=1,0,1,1 with x_valid=1 on cycles 1–4; done=1 on cycle 5 only; start_ready=1 from cycle 6.
- pattern=4'b1010, repeat_n=3, GAP=2 -> x_valid pattern 1111 00 1111 00 1111 (16 cycles); x=0 in gaps; single done after the third copy.
- repeat_n=0, pattern=4'b0110 -> exactly one transmission (0,1,1,0) and one done.
- start_valid held high throughout a burst, with pattern changed mid-burst -> original bits sent uninterrupted; next burst accepted only on the cycle after DONE, carrying the new pattern.
- abort asserted in the cycle presenting bit 2 of 4'b1101 -> x_valid=0 from the next cycle, ps=2'b00, done never pulses, start_ready=1.
- rst pulsed asynchronously (between edges) during GAP_S -> all outputs read reset values before the next clock edge; after release, a new handshake produces a normal burst.
- Loopback: x drives the team's 101 detector's serial input `x` with pattern 4'b1010, repeat_n=2, GAP=0 -> detector output y pulses high once per "101" occurrence in the stream 10101010.

Source files
------------

// File: rtl/seq_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_gen
//  Description : Serial pattern transmitter. Takes a WIDTH-bit pattern via a
//                valid/ready handshake and shifts it out MSB-first on x, one
//                bit per clock, repeating it a programmable number of times
//                with GAP idle cycles between copies. Pulses done once per
//                completed burst and exposes its present state on ps.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       ps
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP_S = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Counter widths sized so the largest loaded value always fits.
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
  localparam bit               HAS_GAP  = (GAP > 0);

  state_t           state;
  logic [WIDTH-1:0] pat_reg;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // The bit currently on x is shreg's MSB; the next one comes from the
  // left-shifted copy.
  assign shreg_nxt = shreg << 1;

  assign ps = state;

  // Burst controller: state, counters and every output are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pat_reg     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      gap_cnt     <= '0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // start_ready is high throughout IDLE, so start_valid alone fires
          // the handshake; abort has no meaning here.
          if (start_valid) begin
            pat_reg     <= pattern;
            shreg       <= pattern;
            rep_cnt     <= (repeat_n == '0) ? REP_ONE : repeat_n;
            bit_cnt     <= BIT_LAST;
            gap_cnt     <= '0;
            x           <= pattern[WIDTH-1];
            x_valid     <= 1'b1;
            busy        <= 1'b1;
            start_ready <= 1'b0;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (abort) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_ready <= 1'b1;
          end else if (bit_cnt != '0) begin
            shreg   <= shreg_nxt;
            x       <= shreg_nxt[WIDTH-1];
            bit_cnt <= bit_cnt - BIT_ONE;
          end else if (rep_cnt > REP_ONE) begin
            rep_cnt <= rep_cnt - REP_ONE;
            if (HAS_GAP) begin
              gap_cnt <= GAP_LOAD;
              x       <= 1'b0;
              x_valid <= 1'b0;
              state   <= GAP_S;
            end else begin
              // Back-to-back repeat: reload without a bubble.
              shreg   <= pat_reg;
              bit_cnt <= BIT_LAST;
              x       <= pat_reg[WIDTH-1];
            end
          end else begin
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        GAP_S: begin
          if (abort) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
            x           <= 1'b0;
            x_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_ready <= 1'b1;
          end else if (gap_cnt == '0) begin
            shreg   <= pat_reg;
            bit_cnt <= BIT_LAST;
            x       <= pat_reg[WIDTH-1];
            x_valid <= 1'b1;
            state   <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end

        DONE: begin
          // done lasts exactly this one cycle; abort cannot cancel it.
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
          rep_cnt     <= '0;
          bit_cnt     <= '0;
          gap_cnt     <= '0;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          x           <= 1'b0;
          x_valid     <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_gen
//  Description : Self-checking bench for seq_gen. Two instances (GAP=0 and
//                GAP=2) share stimulus; each is compared every cycle against
//                a burst-position model derived from the transmit rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       abort;
  logic [3:0] pattern;
  logic [3:0] repeat_n;

  logic       sr0, x0, xv0, busy0, done0;
  logic [1:0] ps0;
  logic       sr2, x2, xv2, busy2, done2;
  logic [1:0] ps2;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector layout: {ps, busy, done, start_ready, x_valid, x}
  localparam logic [6:0] IDLE_E = 7'b00_0_0_1_0_0;
  localparam logic [6:0] GAP_E  = 7'b10_1_0_0_0_0;
  localparam logic [6:0] DONE_E = 7'b11_1_1_0_0_0;

  seq_gen #(.WIDTH(4), .CNT_W(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr0),
    .pattern(pattern), .repeat_n(repeat_n), .abort(abort),
    .x(x0), .x_valid(xv0), .busy(busy0), .done(done0), .ps(ps0)
  );

  seq_gen #(.WIDTH(4), .CNT_W(4), .GAP(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr2),
    .pattern(pattern), .repeat_n(repeat_n), .abort(abort),
    .x(x2), .x_valid(xv2), .busy(busy2), .done(done2), .ps(ps2)
  );

  always #5 clk = ~clk;

  logic [6:0] obs0, obs2, exp0, exp2;
  assign obs0 = {ps0, busy0, done0, sr0, xv0, x0};
  assign obs2 = {ps2, busy2, done2, sr2, xv2, x2};

  // ---------------- reference model: position within a burst ---------------
  logic       m_act [2];
  int         m_t   [2];
  logic [3:0] m_pat [2];
  int         m_r   [2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int burst_len(input int r, input int g);
    return 4 * r + g * (r - 1);
  endfunction

  // Expected outputs at burst position t: copies of WIDTH bits separated by
  // g idle cycles, then a single done cycle at t == burst length.
  function automatic logic [6:0] exp_entry(input logic act, input logic [3:0] pat,
                                           input int r, input int g, input int t);
    int p;
    if (!act) return IDLE_E;
    if (t >= burst_len(r, g)) return DONE_E;
    p = t % (4 + g);
    if (p < 4) return {2'b01, 1'b1, 1'b0, 1'b0, 1'b1, pat[3-p]};
    return GAP_E;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0;
        m_t[i]   <= 0;
      end else if (!m_act[i]) begin
        if (start_valid) begin
          m_act[i] <= 1'b1;
          m_t[i]   <= 0;
          m_pat[i] <= pattern;
          m_r[i]   <= (repeat_n == 4'd0) ? 1 : int'(repeat_n);
        end
      end else if (m_t[i] >= burst_len(m_r[i], gap_of(i))) begin
        m_act[i] <= 1'b0;
      end else if (abort) begin
        m_act[i] <= 1'b0;
      end else begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  always_comb begin
    exp0 = exp_entry(m_act[0], m_pat[0], m_r[0], 0, m_t[0]);
    exp2 = exp_entry(m_act[1], m_pat[1], m_r[1], 2, m_t[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0; pattern = '0; repeat_n = '0;
    #12;
    n_checks++;
    if (obs0 !== IDLE_E) begin n_fail++; $display("FAIL reset_u0: got %b want %b", obs0, IDLE_E); end
    n_checks++;
    if (obs2 !== IDLE_E) begin n_fail++; $display("FAIL reset_u2: got %b want %b", obs2, IDLE_E); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] bits = '0;
    int nvalid = 0, done_cyc = -1, ndone = 0;
    pattern = 4'b1011; repeat_n = 4'd1; start_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL single_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL single_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      if (xv0) begin bits = {bits[2:0], x0}; nvalid++; end
      if (done0) begin ndone++; done_cyc = c; end
      tick();
      start_valid = 1'b0;
    end
    n_checks++;
    if (bits !== 4'b1011 || nvalid != 4) begin n_fail++; $display("FAIL single_bits: got %b/%0d want 1011/4", bits, nvalid); end
    n_checks++;
    if (ndone != 1 || done_cyc != 5) begin n_fail++; $display("FAIL single_done: got %0d pulses at %0d want 1 at 5", ndone, done_cyc); end
  endtask

  task automatic test_repeat_gap();
    logic [15:0] vseq = '0;
    int ndone = 0, nvalid = 0;
    pattern = 4'b1010; repeat_n = 4'd3; start_valid = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL gap_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL gap_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      if (c >= 1 && c <= 16) vseq = {vseq[14:0], xv2};
      if (xv2) nvalid++;
      if (!xv2 && x2) begin n_fail++; $display("FAIL gap_x_idle cyc %0d: got x=1 want 0", c); end
      if (done2) ndone++;
      tick();
      start_valid = 1'b0;
    end
    n_checks++;
    if (vseq !== 16'b1111001111001111) begin n_fail++; $display("FAIL gap_valid_seq: got %b want 1111001111001111", vseq); end
    n_checks++;
    if (ndone != 1 || nvalid != 12) begin n_fail++; $display("FAIL gap_counts: got done=%0d valid=%0d want 1/12", ndone, nvalid); end
  endtask

  task automatic test_repeat_zero();
    logic [3:0] bits = '0;
    int nvalid = 0, ndone = 0;
    pattern = 4'b0110; repeat_n = 4'd0; start_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL rep0_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL rep0_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      if (xv0) begin bits = {bits[2:0], x0}; nvalid++; end
      if (done0) ndone++;
      tick();
      start_valid = 1'b0;
    end
    n_checks++;
    if (bits !== 4'b0110 || nvalid != 4 || ndone != 1) begin
      n_fail++; $display("FAIL rep0_burst: got %b/%0d/%0d want 0110/4/1", bits, nvalid, ndone);
    end
  endtask

  task automatic test_back_to_back();
    start_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL b2b_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL b2b_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      tick();
      pattern  = 4'($urandom);
      repeat_n = 4'($urandom_range(0, 2));
      start_valid = (c < 45);
    end
  endtask

  task automatic test_abort();
    int ndone = 0;
    pattern = 4'b1101; repeat_n = 4'd1; start_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL abort_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL abort_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      if (c == 3) begin
        n_checks++;
        if (xv0 !== 1'b0 || ps0 !== 2'b00 || sr0 !== 1'b1) begin
          n_fail++; $display("FAIL abort_idle: got xv=%b ps=%b rdy=%b want 0/00/1", xv0, ps0, sr0);
        end
      end
      if (done0 || done2) ndone++;
      tick();
      start_valid = 1'b0;
      abort = (c == 1);
    end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    pattern = 4'($urandom); repeat_n = 4'd2; start_valid = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL arst_pre_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      if (ps2 == 2'b10) found = 1;
      else begin tick(); start_valid = 1'b0; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL arst_gap_timeout: got no GAP_S want GAP_S within 20 cycles"); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs0 !== IDLE_E) begin n_fail++; $display("FAIL arst_u0: got %b want %b", obs0, IDLE_E); end
    n_checks++;
    if (obs2 !== IDLE_E) begin n_fail++; $display("FAIL arst_u2: got %b want %b", obs2, IDLE_E); end
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
    pattern = 4'($urandom); repeat_n = 4'd1; start_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL arst_post_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL arst_post_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      tick();
      start_valid = 1'b0;
    end
  endtask

  task automatic test_loopback();
    logic [2:0] hist = '0;
    int ny = 0;
    pattern = 4'b1010; repeat_n = 4'd2; start_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL loop_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      if (xv0) begin
        hist = {hist[1:0], x0};
        if (hist == 3'b101) ny++;
      end
      tick();
      start_valid = 1'b0;
    end
    n_checks++;
    if (ny != 3) begin n_fail++; $display("FAIL loop_101_count: got %0d want 3", ny); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 330; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0) begin n_fail++; $display("FAIL rand_u0 cyc %0d: got %b want %b", c, obs0, exp0); end
      n_checks++;
      if (obs2 !== exp2) begin n_fail++; $display("FAIL rand_u2 cyc %0d: got %b want %b", c, obs2, exp2); end
      tick();
      if (c < 300) begin
        start_valid = 1'($urandom_range(0, 1));
        pattern     = 4'($urandom);
        repeat_n    = 4'($urandom_range(0, 3));
        abort       = ($urandom_range(0, 11) == 0);
      end else begin
        start_valid = 1'b0;
        abort       = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_repeat_zero();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_loopback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
